// File: rtl/hpc_rnd_source.sv
// Fresh-randomness source for the HPC1 AND gadget.
// A seedable 64-bit Fibonacci LFSR that advances by NRND steps per enabled cycle.
// After each seed load it runs a fixed number of discarded warm-up advances,
// then exposes rnd together with rnd_valid. An all-zero seed is rejected and
// reported on seed_err, so the LFSR can never lock up at zero.
module hpc_rnd_source #(
  parameter int unsigned security_order = 2,
  localparam int unsigned D = security_order + 1,
  parameter int unsigned NRND   = D * (D - 1),
  parameter int unsigned WARMUP = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [63:0]     seed,
  input  logic            seed_valid,
  output logic            seed_ready,
  output logic            seed_err,
  input  logic            en,
  output logic [NRND-1:0] rnd,
  output logic            rnd_valid
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WARMUP = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  logic [1:0]  fsm_q;
  logic [63:0] state_q;
  logic [63:0] state_adv;
  logic [31:0] cnt_q;
  logic        err_q;
  logic        seed_fire;
  logic        seed_accept;

  assign seed_ready  = (fsm_q != ST_WARMUP);
  assign rnd_valid   = (fsm_q == ST_RUN);
  assign rnd         = rnd_valid ? state_q[NRND-1:0] : '0;
  assign seed_err    = err_q;
  assign seed_fire   = seed_valid & seed_ready;
  assign seed_accept = seed_fire & (|seed);

  // NRND unrolled LFSR steps: fb = s63^s62^s60^s59 shifted in at bit 0.
  always_comb begin
    state_adv = state_q;
    for (int unsigned i = 0; i < NRND; i++) begin
      state_adv = {state_adv[62:0],
                   state_adv[63] ^ state_adv[62] ^ state_adv[60] ^ state_adv[59]};
    end
  end

  // Seed load, warm-up countdown and run-time advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= seed_fire & ~(|seed);
      case (fsm_q)
        ST_IDLE: begin
          if (seed_accept) begin
            state_q <= seed;
            cnt_q   <= WARMUP;
            fsm_q   <= (WARMUP == 0) ? ST_RUN : ST_WARMUP;
          end
        end
        ST_WARMUP: begin
          state_q <= state_adv;
          cnt_q   <= cnt_q - 32'd1;
          if (cnt_q == 32'd1) begin
            fsm_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          // A seed load takes priority over a simultaneous advance.
          if (seed_accept) begin
            state_q <= seed;
            cnt_q   <= WARMUP;
            fsm_q   <= (WARMUP == 0) ? ST_RUN : ST_WARMUP;
          end else if (en) begin
            state_q <= state_adv;
          end
        end
        default: begin
          fsm_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hpc_rnd_source.sv
// Scoreboard bench for hpc_rnd_source: two instances (WARMUP=0 and WARMUP=16).
// The driver queues the expected outputs for each cycle; a monitor pops and
// compares them on the falling clock edge.
module tb_hpc_rnd_source;

  typedef struct {
    string      name;
    logic [5:0] rnd;
    logic       valid;
    logic       ready;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [63:0] s0_seed = '0;
  logic        s0_sv = 1'b0, s0_en = 1'b0;
  logic        s0_rdy, s0_err, s0_vld;
  logic [5:0]  s0_rnd;

  logic [63:0] s16_seed = '0;
  logic        s16_sv = 1'b0, s16_en = 1'b0;
  logic        s16_rdy, s16_err, s16_vld;
  logic [5:0]  s16_rnd;

  exp_t q0[$];
  exp_t q16[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  hpc_rnd_source #(.NRND(6), .WARMUP(0)) dut0 (
    .clk(clk), .rst(rst), .seed(s0_seed), .seed_valid(s0_sv),
    .seed_ready(s0_rdy), .seed_err(s0_err), .en(s0_en),
    .rnd(s0_rnd), .rnd_valid(s0_vld)
  );

  hpc_rnd_source #(.NRND(6), .WARMUP(16)) dut16 (
    .clk(clk), .rst(rst), .seed(s16_seed), .seed_valid(s16_sv),
    .seed_ready(s16_rdy), .seed_err(s16_err), .en(s16_en),
    .rnd(s16_rnd), .rnd_valid(s16_vld)
  );

  // Reference: n advances of 6 LFSR steps each.
  function automatic logic [63:0] ref_adv(input logic [63:0] s, input int n);
    logic [63:0] r;
    r = s;
    for (int k = 0; k < n * 6; k++) r = {r[62:0], r[63] ^ r[62] ^ r[60] ^ r[59]};
    return r;
  endfunction

  task automatic exp0(input string n, input logic [5:0] r, input logic v,
                      input logic rdy, input logic e);
    exp_t x;
    x.name = n; x.rnd = r; x.valid = v; x.ready = rdy; x.err = e;
    q0.push_back(x);
  endtask

  task automatic exp16(input string n, input logic [5:0] r, input logic v,
                       input logic rdy, input logic e);
    exp_t x;
    x.name = n; x.rnd = r; x.valid = v; x.ready = rdy; x.err = e;
    q16.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag, input exp_t x, input logic [5:0] r,
                         input logic v, input logic rdy, input logic e);
    tests++;
    if (r !== x.rnd || v !== x.valid || rdy !== x.ready || e !== x.err) begin
      fails++;
      $display("FAIL %s/%s: got rnd=%h vld=%b rdy=%b err=%b, want rnd=%h vld=%b rdy=%b err=%b",
               tag, x.name, r, v, rdy, e, x.rnd, x.valid, x.ready, x.err);
    end
  endtask

  // Monitor: one scoreboard entry per instance per cycle, checked mid-cycle.
  always @(negedge clk) begin
    exp_t x;
    if (q0.size() > 0) begin
      x = q0.pop_front();
      compare("w0", x, s0_rnd, s0_vld, s0_rdy, s0_err);
    end
    if (q16.size() > 0) begin
      x = q16.pop_front();
      compare("w16", x, s16_rnd, s16_vld, s16_rdy, s16_err);
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] s_a, s_b;
    s_a = 64'h0123_4567_89AB_CDEF;
    s_b = 64'hDEAD_BEEF_0000_0001;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle: en pulses have no effect.
    for (int i = 0; i < 4; i++) begin
      s0_en = i[0]; s16_en = ~i[0];
      exp0("idle", 6'h00, 1'b0, 1'b1, 1'b0);
      exp16("idle", 6'h00, 1'b0, 1'b1, 1'b0);
      tick();
    end
    s0_en = 1'b0; s16_en = 1'b0;

    // WARMUP=0: seed 0x2A visible the next cycle, then one advance.
    s0_seed = 64'h2A; s0_sv = 1'b1;
    exp0("pre2a", 6'h00, 1'b0, 1'b1, 1'b0);
    tick();
    s0_sv = 1'b0; s0_en = 1'b1;
    exp0("seed2a", 6'h2A, 1'b1, 1'b1, 1'b0);
    tick();
    s0_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp0("hold_a80", 6'h00, 1'b1, 1'b1, 1'b0);
      tick();
    end

    // MSB seed: feedback wraps in on the first step.
    s0_seed = 64'h8000_0000_0000_0000; s0_sv = 1'b1;
    exp0("pre_msb", 6'h00, 1'b1, 1'b1, 1'b0);
    tick();
    s0_sv = 1'b0; s0_en = 1'b1;
    exp0("seed_msb", 6'h00, 1'b1, 1'b1, 1'b0);
    tick();
    s0_en = 1'b0;
    exp0("msb_wrap", 6'h20, 1'b1, 1'b1, 1'b0);
    tick();

    // Zero seed in RUN is rejected with a one-cycle error pulse.
    s0_seed = '0; s0_sv = 1'b1;
    exp0("zr_pre", 6'h20, 1'b1, 1'b1, 1'b0);
    tick();
    s0_sv = 1'b0;
    exp0("zr_err", 6'h20, 1'b1, 1'b1, 1'b1);
    tick();
    exp0("zr_clr", 6'h20, 1'b1, 1'b1, 1'b0);
    tick();

    // Seed and en together: load wins, no advance.
    s0_seed = 64'h15; s0_sv = 1'b1; s0_en = 1'b1;
    exp0("both_pre", 6'h20, 1'b1, 1'b1, 1'b0);
    tick();
    s0_sv = 1'b0; s0_en = 1'b0;
    exp0("both_load", 6'h15, 1'b1, 1'b1, 1'b0);
    tick();

    // WARMUP=16: zero seed in IDLE.
    s16_seed = '0; s16_sv = 1'b1;
    exp16("zi_pre", 6'h00, 1'b0, 1'b1, 1'b0);
    tick();
    s16_sv = 1'b0;
    exp16("zi_err", 6'h00, 1'b0, 1'b1, 1'b1);
    tick();
    exp16("zi_clr", 6'h00, 1'b0, 1'b1, 1'b0);
    tick();

    // Warm-up lasts exactly 16 cycles; a seed offered meanwhile is ignored.
    s16_seed = s_a; s16_sv = 1'b1;
    exp16("wu_pre", 6'h00, 1'b0, 1'b1, 1'b0);
    tick();
    s16_sv = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s16_sv = (i == 5);
      s16_seed = (i == 5) ? s_b : s_a;
      exp16("warmup", 6'h00, 1'b0, 1'b0, 1'b0);
      tick();
    end
    s16_sv = 1'b0; s16_en = 1'b1;
    exp16("wu_done", 6'(ref_adv(s_a, 16)), 1'b1, 1'b1, 1'b0);
    tick();
    s16_en = 1'b0;
    exp16("run_adv", 6'(ref_adv(s_a, 17)), 1'b1, 1'b1, 1'b0);
    tick();

    // Reseed with en high, then reset mid-warm-up.
    s16_seed = s_b; s16_sv = 1'b1; s16_en = 1'b1;
    exp16("rs_pre", 6'(ref_adv(s_a, 17)), 1'b1, 1'b1, 1'b0);
    tick();
    s16_sv = 1'b0; s16_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp16("rs_warm", 6'h00, 1'b0, 1'b0, 1'b0);
      tick();
    end
    #1 rst = 1'b1;
    exp16("rst_async", 6'h00, 1'b0, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    exp16("rst_idle", 6'h00, 1'b0, 1'b1, 1'b0);
    tick();

    // Re-seed after reset: full warm-up again, result from the fresh seed.
    s16_seed = s_b; s16_sv = 1'b1;
    exp16("rs2_pre", 6'h00, 1'b0, 1'b1, 1'b0);
    tick();
    s16_sv = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    exp16("rs2_done", 6'(ref_adv(s_b, 16)), 1'b1, 1'b1, 1'b0);
    tick();

    tick();
    tests++;
    if (q0.size() != 0 || q16.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0", q0.size(), q16.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hpc_rnd_source.md
Name: hpc_rnd_source

Overview:
- Fresh-randomness source that sits directly upstream of the HPC1 AND gadget and drives its `rnd` bus: refresh bits plus DOM multiplication bits, one full fresh word per enabled cycle.
- Built around a seedable 64-bit Fibonacci LFSR, unrolled NRND steps per advance.
- Has a seed-load handshake, a configurable warm-up phase, and a valid flag so that masked datapaths only consume randomness after seeding.

Parameters:
- security_order, 2, masking order of the consuming gadget; d = security_order+1 (derived, not overridable).
- NRND, 6, width of `rnd` in bits per cycle (default d*(d-1) for d=3); legal range 1..64.
- WARMUP, 16, number of LFSR advances discarded after each seed load; 0 means go directly to RUN.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- seed  input  64  LFSR seed value.
- seed_valid  input  1  seed offered this cycle.
- seed_ready  output  1  block can accept a seed this cycle.
- seed_err  output  1  one-cycle pulse: offered seed was all-zero and was rejected.
- en  input  1  consumer takes the current `rnd` word; LFSR advances.
- rnd  output  NRND  fresh random bits; equals `state[NRND-1:0]` in RUN, else 0.
- rnd_valid  output  1  `rnd` is usable (high only in RUN).

Behaviour:
- Reset (async, immediate):
  - state=64'h0, FSM=IDLE, warm-up counter=0.
  - rnd=0, rnd_valid=0, seed_err=0, seed_ready=1.
- LFSR step:
  - fb = s[63]^s[62]^s[60]^s[59].
  - s <= {s[62:0], fb}.
- Advance = NRND consecutive steps, computed combinationally within one cycle.
- FSM states:
  - IDLE: unseeded. seed_ready=1, rnd_valid=0.
    - Accepted seed (seed_valid & seed_ready & seed!=0): load state; counter<=WARMUP; go to WARMUP if WARMUP>0, else RUN.
  - WARMUP: seed_ready=0, rnd_valid=0.
    - One advance per cycle, regardless of `en`; counter decrements.
    - When the counter reaches 1 and the advance completes, go to RUN.
    - Total time in WARMUP is exactly WARMUP cycles.
    - seed_valid is ignored.
  - RUN: rnd_valid=1, seed_ready=1.
    - en=1: one advance at the clock edge, so the next cycle shows a fresh word.
    - en=0: state holds and `rnd` is stable.
    - Accepted seed: load the new state, enter WARMUP (or stay in RUN with the new state if WARMUP=0).
    - rnd_valid falls in the cycle after acceptance when WARMUP>0.
    - Simultaneous en=1 and seed accept: the seed load wins; no advance is applied.
- Zero seed:
  - If seed_valid & seed_ready & seed==0: seed_err=1 for exactly the next cycle.
  - State, FSM and outputs are otherwise unchanged, so an all-zero LFSR lock-up is impossible.
- rnd gating: rnd is forced to 0 whenever rnd_valid=0; no unseeded or warm-up bits are ever visible.
- Latency: seed accepted at edge N, first valid word at edge N+WARMUP (after N+1 edges when WARMUP=0, i.e. visible the cycle after acceptance).
- Reset mid-WARMUP or mid-RUN: immediate return to IDLE. The block must be re-seeded; no state is retained.
- Every LFSR, counter and FSM register is reset asynchronously.

Test Plan:
- Reset then idle, no seed -> rnd=0, rnd_valid=0, seed_ready=1 indefinitely; `en` pulses have no effect.
- WARMUP=0, NRND=6, seed=64'h2A accepted -> next cycle rnd_valid=1, rnd=6'h2A. One en=1 cycle -> state=64'hA80, rnd=6'h00. Then en=0 for 5 cycles -> rnd stays 6'h00.
- WARMUP=0, NRND=6, seed=64'h8000_0000_0000_0000, en=1 for one cycle -> state=64'h20, rnd=6'h20 (feedback bit from s[63] wraps in at step 1).
- WARMUP=16, any nonzero seed:
  - rnd_valid=0 and seed_ready=0 for exactly 16 cycles after acceptance.
  - Then rnd_valid=1 with rnd equal to a reference model advanced 16 times.
  - A seed_valid pulse during warm-up is ignored.
- seed=0 offered in IDLE and in RUN -> seed_err single-cycle pulse; state/rnd/rnd_valid unchanged; next nonzero seed accepted normally.
- In RUN, seed_valid and en both high, then rst pulsed mid-WARMUP:
  - New seed is loaded with no advance.
  - rnd_valid drops the following cycle.
  - rst forces rnd=0, rnd_valid=0, FSM IDLE asynchronously, before the next clock edge.
